// File: rtl/adc_capture_ctrl.sv
// adc_capture_ctrl: capture sequencer in the ADC clock domain.
// A trigger starts an optional pre-delay, followed by a capture of i_len+1 words. Each word is
// the raw sum of 2^d consecutive ADC samples and is written to the sample buffer that the FT600
// readout path drains. A one-cycle o_done pulse marks completion for the toggle-based crossing
// back to the FT clock domain.
// Build option: define ADC_CLIP_FLAG_EN to set o_wr_data[15] when any sample in a word's window
// sits at either rail (0 or all ones). Without it, bit 15 is tied to 0 and no clip logic exists.
module adc_capture_ctrl #(
    parameter int unsigned ADC_W  = 10,
    parameter int unsigned MEM_AW = 13,
    parameter int unsigned DLY_W  = 16
) (
    input  logic              i_adc_clk,
    input  logic              rst,
    input  logic              i_trig,
    input  logic              i_abort,
    input  logic [DLY_W-1:0]  i_delay,
    input  logic [2:0]        i_decim,
    input  logic [MEM_AW-1:0] i_len,
    input  logic [ADC_W-1:0]  i_adc_data,
    output logic              o_wr_en,
    output logic [MEM_AW-1:0] o_wr_addr,
    output logic [15:0]       o_wr_data,
    output logic              o_busy,
    output logic              o_done
);

    // 10-bit samples summed over at most 16 clocks fit exactly in 14 bits.
    localparam int unsigned AccW = 14;

    typedef enum logic [1:0] {
        StIdle,
        StDelay,
        StCapture,
        StDone
    } state_e;

    state_e state_q, state_d;

    // Parameters latched at trigger time; inputs are ignored for the rest of the capture.
    logic [DLY_W-1:0]  dly_q, dly_d;
    logic [MEM_AW-1:0] len_q, len_d;
    logic [3:0]        win_max_q, win_max_d;

    // Capture datapath.
    logic [3:0]        win_q, win_d;
    logic [AccW-1:0]   acc_q, acc_d;
    logic [MEM_AW-1:0] addr_q, addr_d;

    // Registered buffer-side outputs.
    logic              wr_en_q, wr_en_d;
    logic [MEM_AW-1:0] wr_addr_q, wr_addr_d;
    logic [15:0]       wr_data_q, wr_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              start;
    logic              abort_active;
    logic              win_last;
    logic              word_last;
    logic [AccW-1:0]   sample_ext;
    logic [AccW-1:0]   sum;

`ifdef ADC_CLIP_FLAG_EN
    logic              clip_q, clip_d;
    logic              sample_clip;
    logic              win_clip;
`endif

    // Window length minus one for a decimation exponent; exponents above 4 clamp to 4.
    function automatic logic [3:0] win_mask(input logic [2:0] decim);
        logic [3:0] m;
        unique case (decim)
            3'd0:    m = 4'd0;
            3'd1:    m = 4'd1;
            3'd2:    m = 4'd3;
            3'd3:    m = 4'd7;
            default: m = 4'd15;
        endcase
        return m;
    endfunction

    // Abort beats a simultaneous trigger in idle.
    assign start        = (state_q == StIdle) && i_trig && !i_abort;
    assign abort_active = (state_q != StIdle) && i_abort;

    assign sample_ext = AccW'(i_adc_data);
    // Sum including the sample taken on this edge, so a window closes without losing it.
    assign sum        = acc_q + sample_ext;
    assign win_last   = (win_q == win_max_q);
    assign word_last  = win_last && (addr_q == len_q);

`ifdef ADC_CLIP_FLAG_EN
    assign sample_clip = (i_adc_data == '0) || (i_adc_data == {ADC_W{1'b1}});
    assign win_clip    = clip_q | sample_clip;
`endif

    // State register.
    always_ff @(posedge i_adc_clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        if (abort_active) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_d = (i_delay == '0) ? StCapture : StDelay;
                    end
                end
                StDelay: begin
                    // dly_q holds the clocks still to wait, including this one.
                    if (dly_q == DLY_W'(1)) begin
                        state_d = StCapture;
                    end
                end
                StCapture: begin
                    if (word_last) begin
                        state_d = StDone;
                    end
                end
                StDone: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // Datapath and output next-state logic.
    always_comb begin
        dly_d     = dly_q;
        len_d     = len_q;
        win_max_d = win_max_q;
        win_d     = win_q;
        acc_d     = acc_q;
        addr_d    = addr_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
`ifdef ADC_CLIP_FLAG_EN
        clip_d    = clip_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    dly_d     = i_delay;
                    len_d     = i_len;
                    win_max_d = win_mask(i_decim);
                    win_d     = '0;
                    acc_d     = '0;
                    addr_d    = '0;
                    busy_d    = 1'b1;
`ifdef ADC_CLIP_FLAG_EN
                    clip_d    = 1'b0;
`endif
                end
            end
            StDelay: begin
                dly_d = dly_q - DLY_W'(1);
            end
            StCapture: begin
                acc_d = sum;
                win_d = win_q + 4'd1;
`ifdef ADC_CLIP_FLAG_EN
                clip_d = win_clip;
`endif
                if (win_last) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q;
                    wr_data_d = {2'b00, sum};
`ifdef ADC_CLIP_FLAG_EN
                    wr_data_d[15] = win_clip;
                    clip_d        = 1'b0;
`endif
                    // Next window starts from zero on this same edge.
                    acc_d  = '0;
                    win_d  = '0;
                    addr_d = addr_q + MEM_AW'(1);
                end
            end
            StDone: begin
                done_d = 1'b1;
                busy_d = 1'b0;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase

        // A partial window is dropped on abort and no completion is reported.
        if (abort_active) begin
            wr_en_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            acc_d   = '0;
            win_d   = '0;
`ifdef ADC_CLIP_FLAG_EN
            clip_d  = 1'b0;
`endif
        end
    end

    // Datapath and output registers.
    always_ff @(posedge i_adc_clk or posedge rst) begin
        if (rst) begin
            dly_q     <= '0;
            len_q     <= '0;
            win_max_q <= '0;
            win_q     <= '0;
            acc_q     <= '0;
            addr_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef ADC_CLIP_FLAG_EN
            clip_q    <= 1'b0;
`endif
        end else begin
            dly_q     <= dly_d;
            len_q     <= len_d;
            win_max_q <= win_max_d;
            win_q     <= win_d;
            acc_q     <= acc_d;
            addr_q    <= addr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef ADC_CLIP_FLAG_EN
            clip_q    <= clip_d;
`endif
        end
    end

    assign o_wr_en   = wr_en_q;
    assign o_wr_addr = wr_addr_q;
    assign o_wr_data = wr_data_q;
    assign o_busy    = busy_q;
    assign o_done    = done_q;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Bench for adc_capture_ctrl: randomized captures checked against a behavioural model that
// computes expected writes (edge, address, data) and completion timing from the sample table.
module tb_adc_capture_ctrl;

    localparam int unsigned ADC_W  = 10;
    localparam int unsigned MEM_AW = 13;
    localparam int unsigned DLY_W  = 16;
    localparam int          SZ     = 4096;
    localparam int          LOGN   = 131072;

    logic              i_adc_clk = 1'b0;
    logic              rst;
    logic              i_trig;
    logic              i_abort;
    logic [DLY_W-1:0]  i_delay;
    logic [2:0]        i_decim;
    logic [MEM_AW-1:0] i_len;
    logic [ADC_W-1:0]  i_adc_data;
    logic              o_wr_en;
    logic [MEM_AW-1:0] o_wr_addr;
    logic [15:0]       o_wr_data;
    logic              o_busy;
    logic              o_done;

    int n_checks = 0;
    int n_fail   = 0;
    int edge_n   = 0;
    int last_k   = 0;

    // Sample taken at edge n is adc_tab[n % SZ].
    logic [ADC_W-1:0] adc_tab [SZ];
    bit               busy_log [LOGN];
    int got_e[$], got_a[$], got_d[$], done_e[$];
    int exp_e[$], exp_a[$], exp_d[$];

    adc_capture_ctrl #(
        .ADC_W (ADC_W),
        .MEM_AW(MEM_AW),
        .DLY_W (DLY_W)
    ) u_dut (
        .i_adc_clk (i_adc_clk),
        .rst       (rst),
        .i_trig    (i_trig),
        .i_abort   (i_abort),
        .i_delay   (i_delay),
        .i_decim   (i_decim),
        .i_len     (i_len),
        .i_adc_data(i_adc_data),
        .o_wr_en   (o_wr_en),
        .o_wr_addr (o_wr_addr),
        .o_wr_data (o_wr_data),
        .o_busy    (o_busy),
        .o_done    (o_done)
    );

    always #5 i_adc_clk = ~i_adc_clk;

    // Edge counter and ADC sample driver.
    initial begin
        i_adc_data = '0;
        forever begin
            @(posedge i_adc_clk);
            edge_n = edge_n + 1;
            #1 i_adc_data = adc_tab[(edge_n + 1) % SZ];
        end
    end

    // Monitor: log outputs after each edge has settled.
    initial begin
        forever begin
            @(negedge i_adc_clk);
            busy_log[edge_n % LOGN] = o_busy;
            if (o_wr_en) begin
                got_e.push_back(edge_n);
                got_a.push_back(int'(o_wr_addr));
                got_d.push_back(int'(o_wr_data));
            end
            if (o_done) done_e.push_back(edge_n);
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic fill_rand();
        int unsigned r;
        for (int i = 0; i < SZ; i++) begin
            r = $urandom_range(0, 15);
            if (r == 0)      adc_tab[i] = '0;
            else if (r == 1) adc_tab[i] = '1;
            else             adc_tab[i] = ADC_W'($urandom);
        end
    endtask

    task automatic fill_const(input int v);
        for (int i = 0; i < SZ; i++) adc_tab[i] = ADC_W'(v);
    endtask

    task automatic clear_logs();
        got_e.delete(); got_a.delete(); got_d.delete(); done_e.delete();
        exp_e.delete(); exp_a.delete(); exp_d.delete();
    endtask

    // abort_w: -2 none, -1 random abort edge, >=0 abort on the edge after word abort_w is written.
    task automatic run_capture(input int dly, input int decim, input int len, input int abort_w,
                               input bit xtrig, input bit ramp);
        int  k, d, n, f, e_last, a_edge, xt_edge, stop, e, sum, s;
        bit  clip;
        clear_logs();
        @(posedge i_adc_clk); #2;
        k      = edge_n + 1;
        last_k = k;
        d      = (decim > 4) ? 4 : decim;
        n      = 1 << d;
        f      = k + 1 + dly;
        e_last = f + (len + 1) * n - 1;
        if (ramp) begin
            for (int i = 0; i < (len + 1) * n; i++) adc_tab[(f + i) % SZ] = ADC_W'(100 + i);
        end
        a_edge = 0;
        if (abort_w == -1)     a_edge = int'($urandom_range(k + 1, e_last));
        else if (abort_w >= 0) a_edge = f + (abort_w + 1) * n;
        xt_edge = (xtrig && a_edge == 0) ? int'($urandom_range(k + 1, e_last + 1)) : 0;

        // Reference: word w sums samples at edges f+w*n .. f+w*n+n-1, written on the last one.
        for (int w = 0; w <= len; w++) begin
            e = f + (w + 1) * n - 1;
            if (a_edge != 0 && e >= a_edge) break;
            sum  = 0;
            clip = 1'b0;
            for (int j = 0; j < n; j++) begin
                s    = int'(adc_tab[(f + w * n + j) % SZ]);
                sum += s;
                if (s == 0 || s == (1 << ADC_W) - 1) clip = 1'b1;
            end
`ifdef ADC_CLIP_FLAG_EN
            if (clip) sum += 32768;
`endif
            exp_e.push_back(e);
            exp_a.push_back(w);
            exp_d.push_back(sum);
        end

        i_delay = DLY_W'(dly);
        i_decim = 3'(decim);
        i_len   = MEM_AW'(len);
        i_trig  = 1'b1;
        i_abort = 1'b0;
        stop    = (a_edge != 0) ? a_edge + 3 : e_last + 4;
        for (int t = k; t < stop; t++) begin
            @(posedge i_adc_clk); #2;
            i_trig  = (t + 1 == xt_edge);
            i_abort = (t + 1 == a_edge);
            i_delay = 16'($urandom);
            i_decim = 3'($urandom);
            i_len   = 13'($urandom);
        end
        i_trig  = 1'b0;
        i_abort = 1'b0;

        check("wr_count", got_e.size(), exp_e.size());
        for (int i = 0; i < exp_e.size() && i < got_e.size(); i++) begin
            check("wr_edge", got_e[i] - k, exp_e[i] - k);
            check("wr_addr", got_a[i], exp_a[i]);
            check("wr_data", got_d[i], exp_d[i]);
        end
        check("busy_start", int'(busy_log[k % LOGN]), 1);
        if (a_edge == 0) begin
            check("done_count", done_e.size(), 1);
            if (done_e.size() > 0) check("done_edge", done_e[0] - k, e_last + 1 - k);
            check("busy_last_wr", int'(busy_log[e_last % LOGN]), 1);
            check("busy_at_done", int'(busy_log[(e_last + 1) % LOGN]), 0);
        end else begin
            check("abort_done_count", done_e.size(), 0);
            check("busy_at_abort", int'(busy_log[a_edge % LOGN]), 0);
        end
    endtask

    initial begin
        int e0;
        rst     = 1'b1;
        i_trig  = 1'b0;
        i_abort = 1'b0;
        i_delay = '0;
        i_decim = '0;
        i_len   = '0;
        fill_rand();
        repeat (3) @(posedge i_adc_clk);
        @(negedge i_adc_clk);
        check("rst_wr_en", int'(o_wr_en), 0);
        check("rst_wr_addr", int'(o_wr_addr), 0);
        check("rst_wr_data", int'(o_wr_data), 0);
        check("rst_busy", int'(o_busy), 0);
        check("rst_done", int'(o_done), 0);
        @(posedge i_adc_clk); #2;
        rst = 1'b0;

        // Ramp 100..107, one word per clock.
        run_capture(0, 0, 7, -2, 1'b0, 1'b1);
        check("ramp_first", got_d.size() > 0 ? got_d[0] : -1, 100);
        check("ramp_last", got_d.size() > 7 ? got_d[7] : -1, 107);
        check("ramp_lat", got_e.size() > 0 ? got_e[0] - last_k : -1, 1);

        // Pre-delay 5, four-sample windows of constant 1000.
        fill_const(1000);
        run_capture(5, 2, 1, -2, 1'b0, 1'b0);
        check("dly_data", got_d.size() > 0 ? got_d[0] : -1, 4000);
        check("dly_lat", got_e.size() > 0 ? got_e[0] - last_k : -1, 9);
        check("dly_gap", got_e.size() > 1 ? got_e[1] - got_e[0] : -1, 4);

        // Decimation exponent 7 clamps to 16 samples of full scale.
        fill_const(1023);
        run_capture(0, 7, 0, -2, 1'b0, 1'b0);
`ifdef ADC_CLIP_FLAG_EN
        check("clamp_data", got_d.size() > 0 ? got_d[0] : -1, 32'hBFF0);
`else
        check("clamp_data", got_d.size() > 0 ? got_d[0] : -1, 16368);
`endif

        // Re-trigger during capture is ignored.
        fill_rand();
        run_capture(3, 1, 15, -2, 1'b1, 1'b0);

        // Abort after write 3, then a clean capture.
        run_capture(0, 0, 9, 3, 1'b0, 1'b0);
        run_capture(0, 0, 9, -2, 1'b0, 1'b0);

        // Abort and trigger together in idle: nothing starts.
        clear_logs();
        @(posedge i_adc_clk); #2;
        i_trig  = 1'b1;
        i_abort = 1'b1;
        @(posedge i_adc_clk); #2;
        e0      = edge_n;
        i_trig  = 1'b0;
        i_abort = 1'b0;
        repeat (6) @(posedge i_adc_clk);
        #2;
        check("idle_abort_wr", got_e.size(), 0);
        check("idle_abort_busy", int'(busy_log[e0 % LOGN]), 0);

        // Asynchronous reset in the middle of a capture.
        @(posedge i_adc_clk); #2;
        i_delay = '0;
        i_decim = '0;
        i_len   = MEM_AW'(100);
        i_trig  = 1'b1;
        @(posedge i_adc_clk); #2;
        i_trig = 1'b0;
        repeat (4) @(posedge i_adc_clk);
        #3;
        check("pre_rst_wr_en", int'(o_wr_en), 1);
        rst = 1'b1;
        #1;
        check("arst_wr_en", int'(o_wr_en), 0);
        check("arst_wr_addr", int'(o_wr_addr), 0);
        check("arst_wr_data", int'(o_wr_data), 0);
        check("arst_busy", int'(o_busy), 0);
        check("arst_done", int'(o_done), 0);
        @(posedge i_adc_clk); #2;
        rst = 1'b0;
        run_capture(2, 1, 5, -2, 1'b0, 1'b0);

        // Full-depth capture: addresses 0..8191 with no wrap.
        run_capture(0, 0, (1 << MEM_AW) - 1, -2, 1'b0, 1'b0);
        check("full_last_addr", got_a.size() > 0 ? got_a[got_a.size() - 1] : -1, 8191);

        // Randomized captures with optional abort or mid-capture re-trigger.
        for (int it = 0; it < 30; it++) begin
            int unsigned mode;
            fill_rand();
            mode = $urandom_range(0, 3);
            run_capture(int'($urandom_range(0, 12)), int'($urandom_range(0, 7)),
                        int'($urandom_range(0, 20)), (mode == 0) ? -1 : -2,
                        (mode == 1), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/adc_capture_ctrl.md
Name: adc_capture_ctrl

Overview:
- ADC-clock-domain capture sequencer feeding the 16-bit sample buffer that the FT600 readout path drains.
- On a synchronized trigger pulse it waits a programmable pre-delay, then produces sample words at buffer addresses 0..i_len, one write per decimation window.
- Each word is a raw (unaveraged) sum of 2^d ADC samples.
- Emits a one-cycle done pulse for the toggle-based crossing back to the FT clock domain.

Parameters:
- ADC_W, 10, ADC sample width.
- MEM_AW, 13, buffer address width; max capture 2^MEM_AW words.
- DLY_W, 16, pre-delay counter width.

Ports:
- i_adc_clk  input  1  capture clock; all logic on rising edge.
- rst  input  1  asynchronous active-high reset.
- i_trig  input  1  single-cycle start pulse, already synchronized to i_adc_clk.
- i_abort  input  1  level; stop the capture.
- i_delay  input  DLY_W  pre-delay in clocks.
- i_decim  input  3  log2 of decimation factor d; values above 4 clamp to 4.
- i_len  input  MEM_AW  number of words minus 1.
- i_adc_data  input  ADC_W  raw ADC sample.
- o_wr_en  output  1  buffer write strobe.
- o_wr_addr  output  MEM_AW  buffer write address.
- o_wr_data  output  16  buffer write data.
- o_busy  output  1  capture in progress.
- o_done  output  1  one-cycle completion pulse.

Behaviour:
- Reset: all outputs 0 and state IDLE, asynchronously on rst high.
- States: IDLE, DELAY, CAPTURE, DONE.
- IDLE:
  - An i_trig sampled high latches i_delay, clamped i_decim and i_len into internal registers.
  - Clears the address counter and accumulator.
  - Sets o_busy, then goes to DELAY, or straight to CAPTURE if i_delay=0.
- DELAY:
  - Counts i_delay clocks, then goes to CAPTURE.
  - With trigger at edge k, the first sample is taken at edge k+1+i_delay.
- CAPTURE:
  - Adds i_adc_data into a 14-bit accumulator at every edge.
  - Window counter runs 0..2^d-1.
  - On the edge that takes the last sample of a window, registers:
    - o_wr_en=1;
    - o_wr_data={1'b0,1'b0,sum[13:0]}, where sum includes that sample;
    - o_wr_addr=current word index.
  - The accumulator restarts from zero in the same edge, with no lost samples.
  - o_wr_en is high for exactly one cycle per word.
  - With d=0 this is one write per clock, and the data equals {6'd0,sample}.
  - After word i_len is written, goes to DONE.
- DONE:
  - o_done=1 for one cycle (the cycle after the final o_wr_en cycle) and o_busy=0 in that same cycle; then IDLE.
- Accumulator width: 10+4 bits, so it cannot overflow with d≤4.
- Address does not wrap within a capture. i_len=2^MEM_AW-1 writes addresses 0..8191 exactly.
- i_trig while not IDLE: ignored, with no restart and no latched-parameter change.
- Input changes during a capture: do not affect it.
- i_abort high in any state other than IDLE:
  - Next edge: IDLE, o_wr_en=0, o_busy=0.
  - No o_done pulse.
- i_abort and i_trig both high in IDLE: abort wins; stays IDLE.
- Pending window: a partially accumulated window at abort is discarded.
- Capture after abort: the next trigger starts cleanly from address 0.

Optional Feature:
- Macro: ADC_CLIP_FLAG_EN.
- Defined:
  - o_wr_data[15] is set if any sample in the word's window equals 0 or {ADC_W{1'b1}}.
  - The flag clears per window.
- Not defined: o_wr_data[15] is constant 0 and no clip logic is built.
- Bits [14:0] are identical in both builds.

Test Plan:
- Trigger with delay=0, decim=0, len=7, ADC ramp 100..107 -> 8 writes on consecutive clocks:
  - addresses 0..7, data 100..107;
  - first write one cycle after first sample edge;
  - o_done one cycle after the addr-7 write;
  - o_busy low with done.
- delay=5, decim=2, len=1, constant ADC=1000 -> first sample 6 edges after trigger; 2 writes 4 clocks apart, each data 4000.
- decim=7 (clamped to 4), ADC=1023 constant, len=0 -> one write data 16368; with ADC_CLIP_FLAG_EN, bit15=1 (data 0xBFF0).
- Second i_trig mid-capture, len=15 -> exactly 16 writes, addresses 0..15, single o_done.
- i_abort at write 3 of len=9 -> no further o_wr_en and no o_done. Fresh trigger then writes addresses 0..9 and pulses o_done.
- Assert rst asynchronously mid-CAPTURE -> all outputs 0 before the next clock edge. After release, the FSM is in IDLE and accepts a new trigger.
